// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer: multi-digit BCD countdown with prescaled tick, start/pause and one-cycle done pulse.
// Optional feature: define AUTO_RELOAD_EN to reload the last preset and keep running after each DONE.
module bcd_countdown_timer #(
   parameter int DIGITS   = 4,
   parameter int PRESCALE = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   preset,
   input  logic                  start,
   input  logic                  pause,
   output logic [4*DIGITS-1:0]   q,
   output logic                  running,
   output logic                  done,
   output logic                  zero
);
   localparam int W  = 4*DIGITS;
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   q_q, q_d, sat_preset, q_dec;
   logic [PW-1:0]  pre_q, pre_d;
   logic           running_q, done_q, tick, borrow;
`ifdef AUTO_RELOAD_EN
   logic [W-1:0]   shadow_q, shadow_d;
`endif

   assign tick    = (pre_q == LAST);
   assign q       = q_q;
   assign running = running_q;
   assign done    = done_q;
   assign zero    = (q_q == '0);

   // clamp preset digits to 9 and form the borrow-chained decrement of q
   always_comb begin
      sat_preset = '0;
      q_dec      = '0;
      borrow     = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         sat_preset[4*i+:4] = (preset[4*i+:4] > 4'd9) ? 4'd9 : preset[4*i+:4];
         q_dec[4*i+:4]      = !borrow ? q_q[4*i+:4] :
                              (q_q[4*i+:4] == 4'd0) ? 4'd9 : q_q[4*i+:4] - 4'd1;
         borrow             = borrow && (q_q[4*i+:4] == 4'd0);
      end
   end

   // next-state, count and prescaler; load overrides everything, pause beats the tick
   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      pre_d   = pre_q;
`ifdef AUTO_RELOAD_EN
      shadow_d = shadow_q;
`endif
      if (load) begin
         q_d     = sat_preset;
         pre_d   = '0;
         state_d = IDLE;
`ifdef AUTO_RELOAD_EN
         shadow_d = sat_preset;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (start && q_q != '0) begin
                  state_d = RUN;
                  pre_d   = '0;
               end
            end
            RUN: begin
               if (pause) begin
                  state_d = PAUSE;
               end else begin
                  pre_d = tick ? '0 : pre_q + 1'b1;
                  if (tick) begin
                     q_d = q_dec;
                     if (q_dec == '0) state_d = DONE;
                  end
               end
            end
            PAUSE: begin
               if (start) state_d = RUN;
            end
            DONE: begin
`ifdef AUTO_RELOAD_EN
               if (shadow_q != '0) begin
                  q_d     = shadow_q;
                  pre_d   = '0;
                  state_d = RUN;
               end else begin
                  state_d = IDLE;
               end
`else
               state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // state, count, prescaler and registered status flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         q_q       <= '0;
         pre_q     <= '0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
`ifdef AUTO_RELOAD_EN
         shadow_q  <= '0;
`endif
      end else begin
         state_q   <= state_d;
         q_q       <= q_d;
         pre_q     <= pre_d;
         running_q <= (state_d == RUN);
         done_q    <= (state_d == DONE);
`ifdef AUTO_RELOAD_EN
         shadow_q  <= shadow_d;
`endif
      end
   end
endmodule
